// File: rtl/tl_ul_lim_arbiter.sv
// tl_ul_lim_arbiter: two-master TL-UL arbiter in front of the LIM/buffer slave.
// The A channel is round-robin with a grant lock while a beat is stalled.
// The master ID is prepended to the A source, and D responses are routed back by that bit.
// Per-master in-flight counters cap the outstanding requests.
module tl_ul_lim_arbiter #(
   parameter int SRC_W        = 2,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                clock,
   input  logic                reset,
   // master 0 (core data port)
   input  logic                m0_a_valid,
   output logic                m0_a_ready,
   input  logic [2:0]          m0_a_opcode,
   input  logic [2:0]          m0_a_param,
   input  logic [2:0]          m0_a_size,
   input  logic [SRC_W-1:0]    m0_a_source,
   input  logic [ADDR_W-1:0]   m0_a_address,
   input  logic [DATA_W/8-1:0] m0_a_mask,
   input  logic [DATA_W-1:0]   m0_a_data,
   output logic                m0_d_valid,
   input  logic                m0_d_ready,
   output logic [2:0]          m0_d_opcode,
   output logic [2:0]          m0_d_size,
   output logic [SRC_W-1:0]    m0_d_source,
   output logic [DATA_W-1:0]   m0_d_data,
   output logic                m0_d_denied,
   // master 1 (system/debug port)
   input  logic                m1_a_valid,
   output logic                m1_a_ready,
   input  logic [2:0]          m1_a_opcode,
   input  logic [2:0]          m1_a_param,
   input  logic [2:0]          m1_a_size,
   input  logic [SRC_W-1:0]    m1_a_source,
   input  logic [ADDR_W-1:0]   m1_a_address,
   input  logic [DATA_W/8-1:0] m1_a_mask,
   input  logic [DATA_W-1:0]   m1_a_data,
   output logic                m1_d_valid,
   input  logic                m1_d_ready,
   output logic [2:0]          m1_d_opcode,
   output logic [2:0]          m1_d_size,
   output logic [SRC_W-1:0]    m1_d_source,
   output logic [DATA_W-1:0]   m1_d_data,
   output logic                m1_d_denied,
   // slave port
   output logic                s_a_valid,
   input  logic                s_a_ready,
   output logic [2:0]          s_a_opcode,
   output logic [2:0]          s_a_param,
   output logic [2:0]          s_a_size,
   output logic [SRC_W:0]      s_a_source,
   output logic [ADDR_W-1:0]   s_a_address,
   output logic [DATA_W/8-1:0] s_a_mask,
   output logic [DATA_W-1:0]   s_a_data,
   input  logic                s_d_valid,
   output logic                s_d_ready,
   input  logic [2:0]          s_d_opcode,
   input  logic [2:0]          s_d_size,
   input  logic [SRC_W:0]      s_d_source,
   input  logic [DATA_W-1:0]   s_d_data,
   input  logic                s_d_denied
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             lock_q, lock_d;
   logic             lock_id_q, lock_id_d;
   logic             last_win_q, last_win_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic elig0, elig1, grant, grant_elig, a_fire;
   logic d_sel, d_fire0, d_fire1, a_fire0, a_fire1;

   // Grant selection and the combinational A mux; the lock pins the grant to a stalled beat.
   always_comb begin
      elig0 = m0_a_valid && (cnt0_q < CNT_MAX);
      elig1 = m1_a_valid && (cnt1_q < CNT_MAX);
      grant = 1'b0;
      if (lock_q)              grant = lock_id_q;
      else if (elig0 && elig1) grant = !last_win_q;
      else if (elig1)          grant = 1'b1;
      grant_elig = grant ? elig1 : elig0;

      s_a_valid   = grant_elig && !reset;
      s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
      s_a_param   = grant ? m1_a_param   : m0_a_param;
      s_a_size    = grant ? m1_a_size    : m0_a_size;
      s_a_source  = {grant, (grant ? m1_a_source : m0_a_source)};
      s_a_address = grant ? m1_a_address : m0_a_address;
      s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
      s_a_data    = grant ? m1_a_data    : m0_a_data;

      m0_a_ready = s_a_ready && !grant && elig0 && !reset;
      m1_a_ready = s_a_ready &&  grant && elig1 && !reset;

      a_fire  = s_a_valid && s_a_ready;
      a_fire0 = a_fire && !grant;
      a_fire1 = a_fire &&  grant;
   end

   // D routing by the tag bit; non-handshake fields go to both masters unchanged.
   always_comb begin
      d_sel       = s_d_source[SRC_W];
      m0_d_valid  = s_d_valid && !d_sel && !reset;
      m1_d_valid  = s_d_valid &&  d_sel && !reset;
      s_d_ready   = (d_sel ? m1_d_ready : m0_d_ready) && !reset;
      m0_d_opcode = s_d_opcode;
      m1_d_opcode = s_d_opcode;
      m0_d_size   = s_d_size;
      m1_d_size   = s_d_size;
      m0_d_source = s_d_source[SRC_W-1:0];
      m1_d_source = s_d_source[SRC_W-1:0];
      m0_d_data   = s_d_data;
      m1_d_data   = s_d_data;
      m0_d_denied = s_d_denied;
      m1_d_denied = s_d_denied;
      d_fire0     = m0_d_valid && m0_d_ready;
      d_fire1     = m1_d_valid && m1_d_ready;
   end

   // Next state: lock, round-robin pointer and in-flight counters (D on an empty counter saturates at 0).
   always_comb begin
      lock_d     = lock_q;
      lock_id_d  = lock_id_q;
      last_win_d = last_win_q;
      cnt0_d     = cnt0_q;
      cnt1_d     = cnt1_q;

      if (a_fire) begin
         lock_d     = 1'b0;
         last_win_d = grant;
      end else if (s_a_valid) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end

      if (a_fire0 && !d_fire0)                      cnt0_d = cnt0_q + CNT_ONE;
      else if (d_fire0 && !a_fire0 && cnt0_q != '0) cnt0_d = cnt0_q - CNT_ONE;

      if (a_fire1 && !d_fire1)                      cnt1_d = cnt1_q + CNT_ONE;
      else if (d_fire1 && !a_fire1 && cnt1_q != '0) cnt1_d = cnt1_q - CNT_ONE;
   end

   // State registers with synchronous reset; m0 wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         lock_q     <= 1'b0;
         lock_id_q  <= 1'b0;
         last_win_q <= 1'b1;
         cnt0_q     <= '0;
         cnt1_q     <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_id_q  <= lock_id_d;
         last_win_q <= last_win_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
      end
   end

endmodule

// File: tb/tb_tl_ul_lim_arbiter.sv
// Scoreboard bench for tl_ul_lim_arbiter: directed cycle scripts push expected
// A/D beats; a negedge monitor pops and compares on every handshake.
module tb_tl_ul_lim_arbiter;
   localparam int SRC_W = 2, ADDR_W = 32, DATA_W = 32, MAX_INFLIGHT = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
   logic [2:0] m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
   logic [SRC_W-1:0] m0_a_source, m1_a_source;
   logic [ADDR_W-1:0] m0_a_address, m1_a_address;
   logic [DATA_W/8-1:0] m0_a_mask, m1_a_mask;
   logic [DATA_W-1:0] m0_a_data, m1_a_data;
   logic m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
   logic [2:0] m0_d_opcode, m0_d_size, m1_d_opcode, m1_d_size;
   logic [SRC_W-1:0] m0_d_source, m1_d_source;
   logic [DATA_W-1:0] m0_d_data, m1_d_data;
   logic m0_d_denied, m1_d_denied;
   logic s_a_valid, s_a_ready;
   logic [2:0] s_a_opcode, s_a_param, s_a_size;
   logic [SRC_W:0] s_a_source;
   logic [ADDR_W-1:0] s_a_address;
   logic [DATA_W/8-1:0] s_a_mask;
   logic [DATA_W-1:0] s_a_data;
   logic s_d_valid, s_d_ready;
   logic [2:0] s_d_opcode, s_d_size;
   logic [SRC_W:0] s_d_source;
   logic [DATA_W-1:0] s_d_data;
   logic s_d_denied;

   tl_ul_lim_arbiter #(.SRC_W(SRC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clock(clock), .reset(reset),
      .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param),
      .m0_a_size(m0_a_size), .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
      .m0_a_data(m0_a_data), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
      .m0_d_size(m0_d_size), .m0_d_source(m0_d_source), .m0_d_data(m0_d_data), .m0_d_denied(m0_d_denied),
      .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param),
      .m1_a_size(m1_a_size), .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
      .m1_a_data(m1_a_data), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
      .m1_d_size(m1_d_size), .m1_d_source(m1_d_source), .m1_d_data(m1_d_data), .m1_d_denied(m1_d_denied),
      .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),
      .s_a_size(s_a_size), .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
      .s_a_data(s_a_data), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
      .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_data(s_d_data), .s_d_denied(s_d_denied)
   );

   int checks = 0;
   int errors = 0;
   logic [37:0] exp_a[$];   // {s_a_source, opcode, address}
   logic [33:0] exp_d0[$];  // {d_source, data}
   logic [33:0] exp_d1[$];
   int out0, out1;          // bench-side outstanding count per master

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // m0 issues Gets with source 01, m1 issues PutFulls with source 10.
   function automatic logic [37:0] ea0(input logic [31:0] addr);
      return {3'b001, 3'd4, addr};
   endfunction
   function automatic logic [37:0] ea1(input logic [31:0] addr);
      return {3'b110, 3'd0, addr};
   endfunction

   // Monitor: compares every A and D handshake against the scoreboard queues.
   initial begin
      out0 = 0;
      out1 = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            out0 = 0;
            out1 = 0;
         end else begin
            if (s_a_valid && s_a_ready) begin
               if (exp_a.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL a_unexpected: got %0h expected none", {s_a_source, s_a_opcode, s_a_address});
               end else chk("a_beat", {26'd0, s_a_source, s_a_opcode, s_a_address}, {26'd0, exp_a.pop_front()});
               if (s_a_source[SRC_W]) out1++; else out0++;
            end
            if (m0_d_valid && m0_d_ready) begin
               chk("d0_outstanding", 64'(out0 != 0), 64'd1);
               if (exp_d0.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL d0_unexpected: got %0h expected none", m0_d_data);
               end else chk("d0_beat", {30'd0, m0_d_source, m0_d_data}, {30'd0, exp_d0.pop_front()});
               if (out0 > 0) out0--;
            end
            if (m1_d_valid && m1_d_ready) begin
               chk("d1_outstanding", 64'(out1 != 0), 64'd1);
               if (exp_d1.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL d1_unexpected: got %0h expected none", m1_d_data);
               end else chk("d1_beat", {30'd0, m1_d_source, m1_d_data}, {30'd0, exp_d1.pop_front()});
               if (out1 > 0) out1--;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_a_ready = 1'b0;
      s_d_valid = 1'b0; m0_d_ready = 1'b0; m1_d_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic q_empty(input string name);
      chk({name, "_queues_empty"}, 64'(exp_a.size() + exp_d0.size() + exp_d1.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m0_a_opcode = 3'd4; m0_a_param = 3'd0; m0_a_size = 3'd2; m0_a_source = 2'b01;
      m0_a_mask = 4'hF; m0_a_data = 32'hA0A0_0000; m0_a_address = '0;
      m1_a_opcode = 3'd0; m1_a_param = 3'd0; m1_a_size = 3'd2; m1_a_source = 2'b10;
      m1_a_mask = 4'hF; m1_a_data = 32'hB1B1_0000; m1_a_address = '0;
      s_d_opcode = 3'd1; s_d_size = 3'd2; s_d_source = '0; s_d_data = '0; s_d_denied = 1'b0;
      idle();

      // handshake outputs are held low while reset is high
      m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
      s_d_valid = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
      step();
      chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
      chk("rst_m0_a_ready", 64'(m0_a_ready), 64'd0);
      chk("rst_m1_a_ready", 64'(m1_a_ready), 64'd0);
      chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
      chk("rst_m0_d_valid", 64'(m0_d_valid), 64'd0);

      // round robin from reset: m0, m1, m0, m1, then both full
      do_reset();
      for (int c = 0; c < 4; c++) begin
         m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
         m0_a_address = 32'h100 + c; m1_a_address = 32'h200 + c;
         #1;
         chk("rr_msb", 64'(s_a_source[SRC_W]), 64'(c % 2));
         exp_a.push_back((c % 2) ? ea1(32'h200 + c) : ea0(32'h100 + c));
         step();
      end
      #1;
      chk("both_full_s_a_valid", 64'(s_a_valid), 64'd0);
      chk("both_full_m0_a_ready", 64'(m0_a_ready), 64'd0);
      q_empty("rr");

      // lock: m0 stalled, m1 arrives while the tie would favour m1
      do_reset();
      m0_a_valid = 1'b1; m0_a_address = 32'h300; s_a_ready = 1'b1;
      #1; exp_a.push_back(ea0(32'h300)); step();
      m0_a_address = 32'h304; s_a_ready = 1'b0;
      #1; chk("lock_c1_valid", 64'(s_a_valid), 64'd1); chk("lock_c1_msb", 64'(s_a_source[SRC_W]), 64'd0); step();
      m1_a_valid = 1'b1; m1_a_address = 32'h400;
      #1; chk("lock_c2_msb", 64'(s_a_source[SRC_W]), 64'd0); chk("lock_c2_m1_ready", 64'(m1_a_ready), 64'd0); step();
      #1; chk("lock_c3_msb", 64'(s_a_source[SRC_W]), 64'd0); step();
      s_a_ready = 1'b1;
      #1; chk("lock_fire_msb", 64'(s_a_source[SRC_W]), 64'd0); exp_a.push_back(ea0(32'h304)); step();
      m0_a_valid = 1'b0;
      #1; chk("lock_next_msb", 64'(s_a_source[SRC_W]), 64'd1); exp_a.push_back(ea1(32'h400)); step();
      idle();
      #1; q_empty("lock");

      // outstanding limit on m0, one D frees a slot
      do_reset();
      m0_a_valid = 1'b1; s_a_ready = 1'b1; m0_a_address = 32'h500;
      #1; exp_a.push_back(ea0(32'h500)); step();
      m0_a_address = 32'h504;
      #1; exp_a.push_back(ea0(32'h504)); step();
      m0_a_address = 32'h508;
      s_d_valid = 1'b1; s_d_source = 3'b001; s_d_data = 32'hD0D0_0001; m0_d_ready = 1'b1;
      #1;
      chk("m0_full_ready", 64'(m0_a_ready), 64'd0);
      chk("m0_full_s_a_valid", 64'(s_a_valid), 64'd0);
      chk("d_m0_valid", 64'(m0_d_valid), 64'd1);
      chk("d_m0_source", 64'(m0_d_source), 64'd1);
      chk("d_m1_valid_low", 64'(m1_d_valid), 64'd0);
      chk("d_bcast_data", 64'(m1_d_data), 64'hD0D0_0001);
      exp_d0.push_back({2'b01, 32'hD0D0_0001});
      step();
      s_d_valid = 1'b0;
      #1; chk("m0_freed_ready", 64'(m0_a_ready), 64'd1); exp_a.push_back(ea0(32'h508)); step();
      idle();
      #1; q_empty("limit");

      // D to m1 back-pressured by m1_d_ready, then the counter frees one slot
      do_reset();
      m1_a_valid = 1'b1; s_a_ready = 1'b1; m1_a_address = 32'h600;
      #1; exp_a.push_back(ea1(32'h600)); step();
      m1_a_address = 32'h604;
      #1; exp_a.push_back(ea1(32'h604)); step();
      m1_a_address = 32'h608;
      s_d_valid = 1'b1; s_d_source = 3'b110; s_d_data = 32'h1111_0002; m0_d_ready = 1'b1; m1_d_ready = 1'b0;
      #1;
      chk("m1_full_ready", 64'(m1_a_ready), 64'd0);
      chk("d_bp_s_d_ready", 64'(s_d_ready), 64'd0);
      chk("d_bp_m0_valid", 64'(m0_d_valid), 64'd0);
      chk("d_bp_m1_valid", 64'(m1_d_valid), 64'd1);
      step();
      m1_d_ready = 1'b1;
      #1;
      chk("d_rel_s_d_ready", 64'(s_d_ready), 64'd1);
      chk("d_rel_m1_a_ready", 64'(m1_a_ready), 64'd0);
      exp_d1.push_back({2'b10, 32'h1111_0002});
      step();
      s_d_valid = 1'b0;
      #1; chk("m1_freed_ready", 64'(m1_a_ready), 64'd1); exp_a.push_back(ea1(32'h608)); step();
      m1_a_address = 32'h60C;
      #1; chk("m1_refull_ready", 64'(m1_a_ready), 64'd0); step();
      idle();
      #1; q_empty("dbp");

      // simultaneous A and D fire on m1 leaves the counter unchanged
      do_reset();
      m1_a_valid = 1'b1; s_a_ready = 1'b1; m1_a_address = 32'h700;
      #1; exp_a.push_back(ea1(32'h700)); step();
      m1_a_address = 32'h704;
      s_d_valid = 1'b1; s_d_source = 3'b101; s_d_data = 32'h2222_0003; m1_d_ready = 1'b1;
      #1;
      chk("same_cyc_m1_a_ready", 64'(m1_a_ready), 64'd1);
      chk("same_cyc_s_d_ready", 64'(s_d_ready), 64'd1);
      exp_a.push_back(ea1(32'h704));
      exp_d1.push_back({2'b01, 32'h2222_0003});
      step();
      s_d_valid = 1'b0; m1_a_address = 32'h708;
      #1; chk("same_cyc_after_ready", 64'(m1_a_ready), 64'd1); exp_a.push_back(ea1(32'h708)); step();
      m1_a_address = 32'h70C;
      #1; chk("same_cyc_full_ready", 64'(m1_a_ready), 64'd0); step();
      idle();
      #1; q_empty("same");

      // reset with cnt0 full and a lock held on m1
      do_reset();
      m0_a_valid = 1'b1; s_a_ready = 1'b1; m0_a_address = 32'h800;
      #1; exp_a.push_back(ea0(32'h800)); step();
      m0_a_address = 32'h804;
      #1; exp_a.push_back(ea0(32'h804)); step();
      m0_a_address = 32'h808; m1_a_valid = 1'b1; m1_a_address = 32'h900; s_a_ready = 1'b0;
      #1; chk("pre_rst_msb", 64'(s_a_source[SRC_W]), 64'd1); chk("pre_rst_m0_ready", 64'(m0_a_ready), 64'd0); step();
      reset = 1'b1; s_a_ready = 1'b1;
      #1; chk("mid_rst_s_a_valid", 64'(s_a_valid), 64'd0); step();
      reset = 1'b0; m0_a_address = 32'h80C; m1_a_address = 32'h904;
      #1;
      chk("post_rst_tie_msb", 64'(s_a_source[SRC_W]), 64'd0);
      chk("post_rst_m0_ready", 64'(m0_a_ready), 64'd1);
      exp_a.push_back(ea0(32'h80C));
      step();
      m0_a_address = 32'h810;
      #1; chk("post_rst_rr_msb", 64'(s_a_source[SRC_W]), 64'd1); exp_a.push_back(ea1(32'h904)); step();
      m1_a_address = 32'h908;
      #1; chk("post_rst_cnt0_clear", 64'(s_a_source[SRC_W]), 64'd0); exp_a.push_back(ea0(32'h810)); step();
      idle();
      step();
      q_empty("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
